// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the three buses around the unified-memory arbiter:
//   - I port : instruction fetch request/response plus flush and stall
//   - D port : load/store request/response plus stall
//   - mem    : single-ported, variable-latency memory request/ack bus
//
// Modports:
//   slave  : the arbiter's view. It consumes I/D requests and mem responses,
//            and drives I/D responses and the memory request.
//   master : the environment's view (pipeline stages plus memory). It is the
//            exact mirror of slave.
//
// Parameters:
//   ADDR_WIDTH : byte address width on all ports
//   DATA_WIDTH : data width; strobe width is DATA_WIDTH/8
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Instruction fetch port
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  // Load/store port
  logic                  d_req;
  logic                  d_we;
  logic [STRB_WIDTH-1:0] d_wstrb;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_stall;

  // Unified memory port
  logic                  mem_req;
  logic                  mem_we;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_wstrb, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_wstrb, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface : mem_port_arbiter_if

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency unified memory between the
// instruction fetch stage (I port) and the MEM-stage load/store unit (D port).
//
// Each access is one req/ack transaction on the memory bus:
//   - Requests are arbitrated in IDLE.
//   - The winner's command is registered onto mem_* and held until mem_ack.
//   - The response is registered back to the winning port with a one-cycle
//     *_valid pulse.
//
// Arbitration:
//   - D has priority.
//   - A starvation counter forces an I win after STARVE_LIMIT consecutive
//     contested D grants.
//   - A port is masked for the cycle its *_valid pulse is high, so it can
//     present its next request.
//
// Fetch flush:
//   - In IDLE, if_flush blocks an I grant.
//   - In BUSY_I, if_flush kills the in-flight fetch. The bus transaction still
//     completes, but its result is dropped.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave, carrying the I port, the D port and the
//           memory bus
//
// Parameters:
//   ADDR_WIDTH   : byte address width (must match bus)
//   DATA_WIDTH   : data width (must match bus)
//   STARVE_LIMIT : contested D grants before I is forced to win (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int              STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e                state_q,      state_d;
  logic                  mem_req_q,    mem_req_d;
  logic                  mem_we_q,     mem_we_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q,  mem_wstrb_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,   if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,    d_rdata_d;
  logic                  if_valid_q,   if_valid_d;
  logic                  d_valid_q,    d_valid_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  kill_q,       kill_d;

  // Arbitration terms
  logic i_cand;
  logic d_cand;
  logic grant_i;
  logic grant_d;
  logic kill_now;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    starve_cnt_d = starve_cnt_q;
    kill_d       = kill_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    // A port in its valid cycle is masked so it can update its request.
    // A flushed fetch is not started.
    i_cand   = bus.if_req & ~if_valid_q & ~bus.if_flush;
    d_cand   = bus.d_req  & ~d_valid_q;

    // A flush arriving together with mem_ack still kills that fetch.
    kill_now = kill_q | bus.if_flush;

    unique case (state_q)
      IDLE: begin
        if (d_cand && i_cand) begin
          if (starve_cnt_q == STARVE_MAX) grant_i = 1'b1;
          else                            grant_d = 1'b1;
        end else if (d_cand) begin
          grant_d = 1'b1;
        end else if (i_cand) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          // A D grant made while a fetch is waiting counts toward starvation.
          if (bus.if_req && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (grant_i) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_wstrb_d  = '0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end

      BUSY_I: begin
        if (bus.if_flush) kill_d = 1'b1;
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          if (!kill_now) begin
            if_rdata_d = bus.mem_rdata;
            if_valid_d = 1'b1;
          end
        end
      end

      BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          // Stores complete with a pulse but leave the load data untouched.
          if (!mem_we_q) d_rdata_d = bus.mem_rdata;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      starve_cnt_q <= '0;
      kill_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the same
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;

  // Stalls are combinational so the hazard logic sees completion in the
  // same cycle as the valid pulse.
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.d_stall   = bus.d_req  & ~d_valid_q;

endmodule : mem_port_arbiter
